hex_entry: RTL

HEX_ENTRY -- requirements
Module: hex_entry

---
 rtl/hex_entry.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hex_entry.sv
// ============================================================================
// Module   : hex_entry
// Purpose  : Four-digit hex entry editor driven by five debounced buttons,
//            with cursor blink mask and commit pulse. Optional auto-repeat on
//            up/down is enabled by defining HEX_ENTRY_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex_entry #(
    parameter int REPEAT_DELAY = 5000000,
    parameter int REPEAT_RATE  = 1000000,
    parameter int BLINK_N      = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    output logic [15:0] value,
    output logic [1:0]  cursor,
    output logic [3:0]  blank,
    output logic [15:0] committed,
    output logic        commit
);

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4,
        ACT_ENTER = 3'd5
    } act_t;

    localparam int c_BTN_UP    = 0;
    localparam int c_BTN_DOWN  = 1;
    localparam int c_BTN_LEFT  = 2;
    localparam int c_BTN_RIGHT = 3;
    localparam int c_BTN_ENTER = 4;

    generate
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || BLINK_N < 1) begin : g_bad_params
            $error("hex_entry: REPEAT_DELAY, REPEAT_RATE and BLINK_N must be >= 1");
        end
    endgenerate

    logic [4:0]         w_btn;
    logic [4:0]         r_btn;
    logic [4:0]         w_press;
    act_t               w_press_act;
    act_t               w_act;
    act_t               r_act;
    logic [15:0]        r_value;
    logic [1:0]         r_cursor;
    logic [15:0]        r_committed;
    logic               r_commit;
    logic [BLINK_N-1:0] r_blink;
    logic [3:0]         w_blank;
    logic               w_rep_step;

    assign w_btn   = {btn_enter, btn_right, btn_left, btn_down, btn_up};
    assign w_press = w_btn & ~r_btn;

    // Same-cycle presses collapse to the single highest-priority one.
    always_comb begin
        w_press_act = ACT_NONE;
        if (w_press[c_BTN_ENTER])      w_press_act = ACT_ENTER;
        else if (w_press[c_BTN_UP])    w_press_act = ACT_UP;
        else if (w_press[c_BTN_DOWN])  w_press_act = ACT_DOWN;
        else if (w_press[c_BTN_LEFT])  w_press_act = ACT_LEFT;
        else if (w_press[c_BTN_RIGHT]) w_press_act = ACT_RIGHT;
    end

`ifdef HEX_ENTRY_AUTOREPEAT_EN
    localparam logic [23:0] c_REP_DELAY = 24'(REPEAT_DELAY);
    localparam logic [23:0] c_REP_RATE  = 24'(REPEAT_RATE);

    logic [23:0] r_rep_cnt;
    logic        r_rep_active;
    logic        r_rep_down;
    logic        r_rep_phase;
    logic        w_rep_held;
    logic        w_rep_hit;

    assign w_rep_held = r_rep_down ? (btn_down && !btn_up) : (btn_up && !btn_down);
    assign w_rep_hit  = (r_rep_cnt == (r_rep_phase ? c_REP_RATE : c_REP_DELAY));
    assign w_rep_step = r_rep_active && w_rep_held && (w_press == 5'd0) && w_rep_hit;

    // r_rep_cnt holds the number of edges elapsed since the press edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt    <= 24'd0;
            r_rep_active <= 1'b0;
            r_rep_down   <= 1'b0;
            r_rep_phase  <= 1'b0;
        end else if (w_press != 5'd0) begin
            r_rep_cnt   <= 24'd1;
            r_rep_phase <= 1'b0;
            if (w_press == 5'b00001 && !btn_down) begin
                r_rep_active <= 1'b1;
                r_rep_down   <= 1'b0;
            end else if (w_press == 5'b00010 && !btn_up) begin
                r_rep_active <= 1'b1;
                r_rep_down   <= 1'b1;
            end else begin
                r_rep_active <= 1'b0;
            end
        end else if (r_rep_active) begin
            if (!w_rep_held) begin
                r_rep_active <= 1'b0;
            end else if (w_rep_hit) begin
                r_rep_cnt   <= 24'd1;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 24'd1;
            end
        end
    end

    always_comb begin
        w_act = w_press_act;
        if (w_press_act == ACT_NONE && w_rep_step)
            w_act = r_rep_down ? ACT_DOWN : ACT_UP;
    end
`else
    assign w_rep_step = 1'b0;

    always_comb begin
        w_act = w_press_act;
    end
`endif

    // Decoded action is registered first, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn       <= w_btn;
            r_act       <= ACT_NONE;
            r_value     <= 16'd0;
            r_cursor    <= 2'd0;
            r_committed <= 16'd0;
            r_commit    <= 1'b0;
            r_blink     <= '0;
        end else begin
            r_btn    <= w_btn;
            r_act    <= w_act;
            r_blink  <= r_blink + 1'b1;
            r_commit <= (r_act == ACT_ENTER);
            case (r_act)
                ACT_UP:    r_value[{r_cursor, 2'b00} +: 4] <= r_value[{r_cursor, 2'b00} +: 4] + 4'd1;
                ACT_DOWN:  r_value[{r_cursor, 2'b00} +: 4] <= r_value[{r_cursor, 2'b00} +: 4] - 4'd1;
                ACT_LEFT:  r_cursor <= r_cursor + 2'd1;
                ACT_RIGHT: r_cursor <= r_cursor - 2'd1;
                ACT_ENTER: r_committed <= r_value;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_blank           = 4'b0000;
        w_blank[r_cursor] = r_blink[BLINK_N-1];
    end

    assign value     = r_value;
    assign cursor    = r_cursor;
    assign blank     = w_blank;
    assign committed = r_committed;
    assign commit    = r_commit;

endmodule

`default_nettype wire
